// File: rtl/wisc_pkg.sv
// Shared definitions for the 16-bit WISC pipeline front end.
// Holds the opcodes used by the redirect/flush logic, the PC width,
// the branch condition codes, and the fetch halt state encoding.
package wisc_pkg;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned CC_W    = 3;
    localparam int unsigned IMM9_W  = 9;
    localparam int unsigned DCNT_W  = 4;

    localparam logic [OP_W-1:0] OP_B   = 4'b1100;
    localparam logic [OP_W-1:0] OP_BR  = 4'b1101;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    // Branch condition codes (instruction bits [11:9]), evaluated by the flush block
    localparam logic [CC_W-1:0] CC_NEQ  = 3'b000;
    localparam logic [CC_W-1:0] CC_EQ   = 3'b001;
    localparam logic [CC_W-1:0] CC_GT   = 3'b010;
    localparam logic [CC_W-1:0] CC_LT   = 3'b011;
    localparam logic [CC_W-1:0] CC_GTE  = 3'b100;
    localparam logic [CC_W-1:0] CC_LTE  = 3'b101;
    localparam logic [CC_W-1:0] CC_OVFL = 3'b110;
    localparam logic [CC_W-1:0] CC_UNC  = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/branch_target_calc.sv
// Branch target computation for B (PC-relative) and BR (register) forms.
// Ports: is_br selects BR; imm9 is the B offset field in halfwords;
// pc_plus2 is PC+2 of the branch; rs_value is the BR register value;
// target_c is the combinational 16-bit target (wraps mod 2^16).
module branch_target_calc
    import wisc_pkg::*;
(
    input  logic              is_br,
    input  logic [IMM9_W-1:0] imm9,
    input  logic [PC_W-1:0]   pc_plus2,
    input  logic [PC_W-1:0]   rs_value,
    output logic [PC_W-1:0]   target_c
);

    logic [PC_W-1:0] offset;

    // Sign-extend the 9-bit halfword offset and scale it to bytes
    assign offset = {{(PC_W-IMM9_W-1){imm9[IMM9_W-1]}}, imm9, 1'b0};

    assign target_c = is_br ? rs_value : PC_W'(pc_plus2 + offset);

endmodule

// File: rtl/fetch_redirect.sv
// Fetch redirect: owns the architectural PC, applies taken branches from ID
// (immediately, or deferred while instruction memory is busy), and drains
// the pipeline after HLT before raising a sticky halted flag.
// Ports: clk/rst (sync, active-high); stall, imem_ready; ID-stage
// id_valid/id_instruction/id_pc_plus2/id_rs_value; take_branch decision;
// outputs pc (registered), pc_plus2, if_id_flush (combinational), halted.
module fetch_redirect
    import wisc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC     = 16'h0000,
    parameter int unsigned     DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            imem_ready,
    input  logic            id_valid,
    input  logic [15:0]     id_instruction,
    input  logic [PC_W-1:0] id_pc_plus2,
    input  logic [PC_W-1:0] id_rs_value,
    input  logic            take_branch,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus2,
    output logic            if_id_flush,
    output logic            halted
);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pend_tgt_q, pend_tgt_d;
    logic              pend_valid_q, pend_valid_d;
    logic [DCNT_W-1:0] cnt_q, cnt_d;
    logic              halted_q, halted_d;

    logic [OP_W-1:0]   opcode;
    logic              is_b, is_br, is_hlt;
    logic              in_run;
    logic              redirect;
    logic              hlt_accept;
    logic [PC_W-1:0]   target;
    logic              unused_cc;

    // Condition code is consumed by the flush block, not here
    assign unused_cc = ^id_instruction[11:9];

    assign opcode = id_instruction[15:12];
    assign is_b   = (opcode == OP_B);
    assign is_br  = (opcode == OP_BR);
    assign is_hlt = (opcode == OP_HLT);
    assign in_run = (state_q == ST_RUN);

    // take_branch is re-qualified so a stray flush never moves the PC
    assign redirect   = in_run & id_valid & (is_b | is_br) & take_branch & ~stall;
    assign hlt_accept = in_run & id_valid & is_hlt & ~stall & ~redirect & ~pend_valid_q;

    branch_target_calc u_target (
        .is_br    (is_br),
        .imm9     (id_instruction[IMM9_W-1:0]),
        .pc_plus2 (id_pc_plus2),
        .rs_value (id_rs_value),
        .target_c (target)
    );

    // Next PC, pending redirect and halt-drain sequencing
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_tgt_d   = pend_tgt_q;
        pend_valid_d = pend_valid_q;
        cnt_d        = cnt_q;
        halted_d     = halted_q;

        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    if (imem_ready) begin
                        pc_d         = target;
                        pend_valid_d = 1'b0;
                    end else begin
                        // Newest redirect replaces any older pending one
                        pend_tgt_d   = target;
                        pend_valid_d = 1'b1;
                    end
                end else if (pend_valid_q && imem_ready && !stall) begin
                    pc_d         = pend_tgt_q;
                    pend_valid_d = 1'b0;
                end else if (hlt_accept) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DCNT_W'(DRAIN_CYCLES - 1);
                end else if (!stall && imem_ready) begin
                    pc_d = PC_W'(pc_q + PC_W'(2));
                end
            end
            ST_DRAIN: begin
                // Fixed-length drain, independent of stall and imem_ready
                if (cnt_q == '0) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - DCNT_W'(1);
                end
            end
            ST_HALTED: begin
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            pend_tgt_q   <= '0;
            pend_valid_q <= 1'b0;
            cnt_q        <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_tgt_q   <= pend_tgt_d;
            pend_valid_q <= pend_valid_d;
            cnt_q        <= cnt_d;
            halted_q     <= halted_d;
        end
    end

    assign pc          = pc_q;
    assign pc_plus2    = PC_W'(pc_q + PC_W'(2));
    assign halted      = halted_q;
    assign if_id_flush = ~rst & (redirect | pend_valid_q | hlt_accept | ~in_run);

endmodule

// File: tb/tb_fetch_redirect.sv
// Bench for fetch_redirect: a directed table of hand-derived vectors for the
// documented sequences, then randomized cycles against a reference model.
module tb_fetch_redirect;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int unsigned DRAIN    = 3;

    logic        clk = 1'b0;
    logic        rst, stall, imem_ready, id_valid, take_branch;
    logic [15:0] id_instruction, id_pc_plus2, id_rs_value;
    logic [15:0] pc, pc_plus2;
    logic        if_id_flush, halted;

    always #5 clk = ~clk;

    fetch_redirect #(.RESET_PC(RESET_PC), .DRAIN_CYCLES(DRAIN)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .imem_ready     (imem_ready),
        .id_valid       (id_valid),
        .id_instruction (id_instruction),
        .id_pc_plus2    (id_pc_plus2),
        .id_rs_value    (id_rs_value),
        .take_branch    (take_branch),
        .pc             (pc),
        .pc_plus2       (pc_plus2),
        .if_id_flush    (if_id_flush),
        .halted         (halted)
    );

    typedef struct {
        logic        rst, stall, imem, valid;
        logic [15:0] instr, pc2, rs;
        logic        take;
        logic        exp_flush;
        logic [15:0] exp_pc;
        logic        exp_halted;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_chk  = 0;
    logic flush_s;

    // Reference model state
    int m_pc, m_pt, m_left;
    bit m_pv, m_drain, m_halt;

    function automatic vec_t mk(input logic r, s, m, va, input logic [15:0] ins, p2, rs_v,
                                input logic t, ef, input logic [15:0] ep, input logic eh);
        vec_t v;
        v.rst = r; v.stall = s; v.imem = m; v.valid = va;
        v.instr = ins; v.pc2 = p2; v.rs = rs_v; v.take = t;
        v.exp_flush = ef; v.exp_pc = ep; v.exp_halted = eh;
        return v;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle: sample the combinational flush mid-cycle, then step past the edge
    task automatic apply(input vec_t v);
        rst = v.rst; stall = v.stall; imem_ready = v.imem; id_valid = v.valid;
        id_instruction = v.instr; id_pc_plus2 = v.pc2; id_rs_value = v.rs;
        take_branch = v.take;
        #3;
        flush_s = if_id_flush;
        @(posedge clk);
        #1;
        n_vec++;
    endtask

    function automatic int op_of(input vec_t v);
        return int'(v.instr[15:12]);
    endfunction

    function automatic int target_of(input vec_t v);
        int s;
        if (op_of(v) == 13) return int'(v.rs);
        s = int'(v.instr[8:0]);
        if (s >= 256) s -= 512;
        return (int'(v.pc2) + 2 * s) & 'hFFFF;
    endfunction

    function automatic bit m_taken(input vec_t v);
        return !m_drain && !m_halt && v.valid && (op_of(v) == 12 || op_of(v) == 13)
               && v.take && !v.stall;
    endfunction

    function automatic bit m_hlt(input vec_t v);
        return !m_drain && !m_halt && v.valid && op_of(v) == 15 && !v.stall
               && !m_taken(v) && !m_pv;
    endfunction

    function automatic bit m_flush(input vec_t v);
        if (v.rst) return 1'b0;
        return m_drain || m_halt || m_pv || m_taken(v) || m_hlt(v);
    endfunction

    task automatic m_step(input vec_t v);
        if (v.rst) begin
            m_pc = int'(RESET_PC); m_pv = 0; m_pt = 0; m_drain = 0; m_halt = 0; m_left = 0;
        end else if (m_drain) begin
            m_left--;
            if (m_left == 0) begin m_drain = 0; m_halt = 1; end
        end else if (!m_halt) begin
            if (m_taken(v)) begin
                if (v.imem) begin m_pc = target_of(v); m_pv = 0; end
                else begin m_pt = target_of(v); m_pv = 1; end
            end else if (m_pv && v.imem && !v.stall) begin
                m_pc = m_pt; m_pv = 0;
            end else if (m_hlt(v)) begin
                m_drain = 1; m_left = int'(DRAIN);
            end else if (!v.stall && v.imem) begin
                m_pc = (m_pc + 2) & 'hFFFF;
            end
        end
    endtask

    initial begin
        // r s m v  instr     pc2       rs        t  flush pc_after  halted
        tbl.push_back(mk(1,0,1,0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0,0,1,1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0002, 0));
        tbl.push_back(mk(0,0,1,1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0004, 0));
        tbl.push_back(mk(0,0,1,1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0006, 0));
        tbl.push_back(mk(0,0,1,1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0008, 0));
        tbl.push_back(mk(0,0,1,1, 16'hC1FE, 16'h0010, 16'h0000, 1, 1, 16'h000C, 0));
        tbl.push_back(mk(0,0,1,1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h000E, 0));
        tbl.push_back(mk(0,1,1,1, 16'hD000, 16'h0010, 16'h4000, 1, 0, 16'h000E, 0));
        tbl.push_back(mk(0,1,1,1, 16'hD000, 16'h0010, 16'h4000, 1, 0, 16'h000E, 0));
        tbl.push_back(mk(0,0,1,1, 16'hD000, 16'h0010, 16'h4000, 1, 1, 16'h4000, 0));
        tbl.push_back(mk(0,0,1,0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h4002, 0));
        tbl.push_back(mk(0,0,0,1, 16'hC008, 16'h00F0, 16'h0000, 1, 1, 16'h4002, 0));
        tbl.push_back(mk(0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h4002, 0));
        tbl.push_back(mk(0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h4002, 0));
        tbl.push_back(mk(0,0,1,0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0100, 0));
        tbl.push_back(mk(0,0,1,0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0102, 0));
        tbl.push_back(mk(0,0,1,1, 16'hF000, 16'h0000, 16'h0000, 0, 1, 16'h0102, 0));
        tbl.push_back(mk(0,0,1,0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0102, 0));
        tbl.push_back(mk(0,0,1,0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0102, 0));
        tbl.push_back(mk(0,0,1,0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0102, 1));
        tbl.push_back(mk(0,0,1,1, 16'hC1FE, 16'h0010, 16'h0000, 1, 1, 16'h0102, 1));
        tbl.push_back(mk(1,0,1,0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0,0,1,1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0002, 0));
        tbl.push_back(mk(0,0,1,1, 16'hF000, 16'h0000, 16'h0000, 0, 1, 16'h0002, 0));
        tbl.push_back(mk(0,0,1,0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0002, 0));
        tbl.push_back(mk(1,0,1,0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0,0,1,1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0002, 0));
        tbl.push_back(mk(0,0,1,1, 16'hD000, 16'h0000, 16'hFFFE, 1, 1, 16'hFFFE, 0));
        tbl.push_back(mk(0,0,1,1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0,0,1,0, 16'hC1FE, 16'h0010, 16'h0000, 1, 0, 16'h0002, 0));
        tbl.push_back(mk(0,0,1,1, 16'h1234, 16'h0010, 16'h0000, 1, 0, 16'h0004, 0));
        tbl.push_back(mk(0,0,1,1, 16'hC1FE, 16'h0010, 16'h0000, 0, 0, 16'h0006, 0));
        tbl.push_back(mk(0,0,0,1, 16'hC008, 16'h00F0, 16'h0000, 1, 1, 16'h0006, 0));
        tbl.push_back(mk(0,0,0,1, 16'hD000, 16'h0000, 16'h2000, 1, 1, 16'h0006, 0));
        tbl.push_back(mk(0,0,1,0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h2000, 0));
        tbl.push_back(mk(0,0,0,1, 16'hD000, 16'h0000, 16'h3000, 1, 1, 16'h2000, 0));
        tbl.push_back(mk(0,1,1,0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h2000, 0));
        tbl.push_back(mk(0,0,1,0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h3000, 0));
        tbl.push_back(mk(0,1,1,1, 16'hF000, 16'h0000, 16'h0000, 0, 0, 16'h3000, 0));
        tbl.push_back(mk(0,0,1,0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h3002, 0));

        foreach (tbl[i]) begin
            logic [15:0] exp_p2;
            apply(tbl[i]);
            exp_p2 = tbl[i].exp_pc + 16'd2;
            check($sformatf("tbl%0d flush", i), {15'b0, flush_s}, {15'b0, tbl[i].exp_flush});
            check($sformatf("tbl%0d pc", i), pc, tbl[i].exp_pc);
            check($sformatf("tbl%0d pc_plus2", i), pc_plus2, exp_p2);
            check($sformatf("tbl%0d halted", i), {15'b0, halted}, {15'b0, tbl[i].exp_halted});
        end

        // Randomized phase against the reference model
        for (int i = 0; i < 800; i++) begin
            vec_t v;
            int   r;
            logic [3:0] op;
            logic       ef;
            v.rst   = (i == 0) || ($urandom_range(0, 59) == 0);
            v.stall = ($urandom_range(0, 3) == 0);
            v.imem  = ($urandom_range(0, 2) != 0);
            v.valid = ($urandom_range(0, 4) != 0);
            r = int'($urandom_range(0, 19));
            if (r == 0)      op = 4'hF;
            else if (r < 6)  op = 4'hC;
            else if (r < 10) op = 4'hD;
            else             op = 4'($urandom_range(0, 11));
            v.instr = {op, 12'($urandom)};
            v.pc2   = 16'($urandom);
            v.rs    = 16'($urandom);
            v.take  = 1'($urandom_range(0, 1));
            ef = m_flush(v);
            apply(v);
            m_step(v);
            check($sformatf("rnd%0d flush", i), {15'b0, flush_s}, {15'b0, ef});
            check($sformatf("rnd%0d pc", i), pc, 16'(m_pc));
            check($sformatf("rnd%0d pc_plus2", i), pc_plus2, 16'((m_pc + 2) & 'hFFFF));
            check($sformatf("rnd%0d halted", i), {15'b0, halted}, {15'b0, 1'(m_halt)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
